// File: rtl/collatz_sweep.sv
// Range sequencer for the collatz iterator: issues one go/n load per start value,
// times each run, and reports the value with the longest stopping time.
module collatz_sweep #(
    parameter int CNT_W     = 16,
    parameter int STEP_W    = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       first,
    input  logic [CNT_W-1:0]  count,
    output logic              go,
    output logic [31:0]       n,
    input  logic              it_done,
    output logic              busy,
    output logic              finished,
    output logic [31:0]       best_n,
    output logic [STEP_W-1:0] best_steps,
    output logic [CNT_W-1:0]  tested,
    output logic [CNT_W-1:0]  timeouts
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, UPDATE, NEXT, DONE} state_t;

    localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0]  CNT_ALL = '1;

    state_t            state, state_d;
    logic [31:0]       cur, cur_d;
    logic [CNT_W-1:0]  rem, rem_d;
    logic [STEP_W-1:0] cnt, cnt_d;
    logic [STEP_W-1:0] steps;
    logic              go_d, busy_d, finished_d;
    logic [31:0]       n_d, best_n_d;
    logic [STEP_W-1:0] best_steps_d;
    logic [CNT_W-1:0]  tested_d, timeouts_d;

    // A start value of 1 is already at the fixed point, whatever the iterator reports.
    assign steps = (cur == 32'd1) ? '0 : cnt;

    always_comb begin
        state_d      = state;
        cur_d        = cur;
        rem_d        = rem;
        cnt_d        = cnt;
        n_d          = n;
        best_n_d     = best_n;
        best_steps_d = best_steps;
        tested_d     = tested;
        timeouts_d   = timeouts;
        go_d         = 1'b0;
        busy_d       = 1'b0;
        finished_d   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cur_d        = first;
                    rem_d        = count;
                    best_n_d     = '0;
                    best_steps_d = '0;
                    tested_d     = '0;
                    timeouts_d   = '0;
                    state_d      = (count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (cur == 32'd0) begin
                    state_d = NEXT;
                end else begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (it_done) begin
                    state_d = UPDATE;
                end else if (cnt == MAX_CNT) begin
                    timeouts_d = (timeouts == CNT_ALL) ? timeouts : timeouts + 1'b1;
                    state_d    = NEXT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            UPDATE: begin
                tested_d = (tested == CNT_ALL) ? tested : tested + 1'b1;
                if (steps > best_steps || tested == '0) begin
                    best_n_d     = cur;
                    best_steps_d = steps;
                end
                state_d = NEXT;
            end
            NEXT: begin
                rem_d   = rem - 1'b1;
                cur_d   = cur + 32'd1;
                state_d = (rem == CNT_W'(1)) ? DONE : LOAD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered.
        go_d       = (state_d == LOAD) && (cur_d != 32'd0);
        busy_d     = (state_d == LOAD) || (state_d == RUN) ||
                     (state_d == UPDATE) || (state_d == NEXT);
        finished_d = (state_d == DONE);
        if (go_d) begin
            n_d = cur_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            rem        <= '0;
            cnt        <= '0;
            go         <= 1'b0;
            n          <= '0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            best_n     <= '0;
            best_steps <= '0;
            tested     <= '0;
            timeouts   <= '0;
        end else begin
            state      <= state_d;
            cur        <= cur_d;
            rem        <= rem_d;
            cnt        <= cnt_d;
            go         <= go_d;
            n          <= n_d;
            busy       <= busy_d;
            finished   <= finished_d;
            best_n     <= best_n_d;
            best_steps <= best_steps_d;
            tested     <= tested_d;
            timeouts   <= timeouts_d;
        end
    end

endmodule
